decoder_nx2n_seq: RTL and testbench

//   Registered, parametrised N-to-2^N one-hot decoder with enable, valid/ready input handshake and three output modes.

---
 rtl/decoder_nx2n_seq_pkg.sv | 15 +
 rtl/decoder_nx2n_seq_onehot.sv | 17 +
 rtl/decoder_nx2n_seq.sv | 129 ++++++++++++
 tb/tb_decoder_nx2n_seq.sv | 138 +++++++++++++
 4 files changed

// File: rtl/decoder_nx2n_seq_pkg.sv
// Shared constants for the sequential N-to-2^N decoder: mode encodings and FSM state codes.
package decoder_nx2n_seq_pkg;

    // Output mode encodings on the mode input; 2'b11 is reserved and behaves as LEVEL.
    localparam logic [1:0] MODE_LEVEL = 2'b00;
    localparam logic [1:0] MODE_PULSE = 2'b01;
    localparam logic [1:0] MODE_SCAN  = 2'b10;

    // FSM state codes.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_HOLD  = 2'b01;
    localparam logic [1:0] ST_PULSE = 2'b10;
    localparam logic [1:0] ST_SCAN  = 2'b11;

endpackage

// File: rtl/decoder_nx2n_seq_onehot.sv
// Combinational N-to-2^N one-hot decode with enable; onehot[0] corresponds to sel == 0.
module decoder_nx2n_seq_onehot
    import decoder_nx2n_seq_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]   sel,
    input  logic           en,
    output logic [0:2**N-1] onehot
);

    // One comparator per output bit; at most one can match, so the result is never multi-hot.
    for (genvar gi = 0; gi < 2**N; gi++) begin : g_bit
        assign onehot[gi] = en && (sel == N'(gi));
    end

endmodule

// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2^N one-hot decoder with valid/ready input, LEVEL / PULSE / SCAN output modes,
// synchronous abort and optional active-low output polarity.
module decoder_nx2n_seq
    import decoder_nx2n_seq_pkg::*;
#(
    parameter int N            = 2,
    parameter int PULSE_CYCLES = 1,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    sel,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            clear,
    output logic [0:2**N-1] z,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(PULSE_CYCLES + 1);

    logic [1:0]       state_reg, state_next;
    logic [N-1:0]     idx_reg, idx_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             act_reg, act_next;
    logic             done_reg, done_next;
    logic [0:2**N-1]  z_reg, z_next;
    logic             accept;

    assign in_ready = (state_reg == ST_IDLE) || (state_reg == ST_HOLD);
    assign busy     = (state_reg == ST_PULSE) || (state_reg == ST_SCAN);
    assign accept   = in_valid && in_ready;

    // Next-state logic: clear forces idle ahead of any accept; busy states run to completion.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        act_next   = act_reg;
        done_next  = 1'b0;
        if (clear) begin
            state_next = ST_IDLE;
            idx_next   = '0;
            cnt_next   = '0;
            act_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_PULSE: begin
                    if (cnt_reg == '0) begin
                        act_next   = 1'b0;
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt_reg - CW'(1);
                    end
                end
                ST_SCAN: begin
                    // Walk upward to the top output only; no wrap back to 0.
                    if (idx_reg == '1) begin
                        act_next   = 1'b0;
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        idx_next = idx_reg + N'(1);
                    end
                end
                default: begin
                    if (accept) begin
                        idx_next = sel;
                        if (!en) begin
                            act_next   = 1'b0;
                            state_next = ST_IDLE;
                        end else begin
                            act_next = 1'b1;
                            case (mode)
                                MODE_PULSE: begin
                                    cnt_next   = CW'(PULSE_CYCLES - 1);
                                    state_next = ST_PULSE;
                                end
                                MODE_SCAN: begin
                                    state_next = ST_SCAN;
                                end
                                default: begin
                                    done_next  = 1'b1;
                                    state_next = ST_HOLD;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Decode the upcoming index so the output register changes in the same cycle as the state.
    decoder_nx2n_seq_onehot #(
        .N (N)
    ) u_onehot (
        .sel    (idx_next),
        .en     (act_next),
        .onehot (z_next)
    );

    // State, index, counter and output registers; rst overrides clear and accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            act_reg   <= 1'b0;
            done_reg  <= 1'b0;
            z_reg     <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            act_reg   <= act_next;
            done_reg  <= done_next;
            z_reg     <= z_next;
        end
    end

    assign z    = ACTIVE_LOW ? ~z_reg : z_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Scoreboard bench: each step drives inputs, queues the expected outputs for after the next
// clock edge, then pops and compares them 1 time unit after that edge.
module tb_decoder_nx2n_seq;
    import decoder_nx2n_seq_pkg::*;

    typedef struct {
        string      tag;
        logic [3:0] z;
        logic       done;
        logic       ready;
        logic       busy;
        logic       chk_al;
        logic [7:0] z_al;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en, in_valid, clear;
    logic [1:0] sel, mode;
    logic [2:0] sel_al;
    logic       in_ready, busy, done;
    logic [0:3] z;
    logic       in_ready_al, busy_al, done_al;
    logic [0:7] z_al;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    decoder_nx2n_seq #(.N(2), .PULSE_CYCLES(3), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .sel(sel), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .clear(clear), .z(z), .busy(busy), .done(done)
    );

    decoder_nx2n_seq #(.N(3), .PULSE_CYCLES(1), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .sel(sel_al), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready_al), .clear(clear), .z(z_al), .busy(busy_al), .done(done_al)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // One clock: drive inputs, queue expectation, sample after the edge and compare.
    task automatic step(input string tag, input logic r, input logic v, input logic [1:0] s,
                        input logic e, input logic [1:0] m, input logic c,
                        input logic [3:0] ez, input logic ed, input logic er, input logic eb);
        exp_t x;
        rst = r; in_valid = v; sel = s; en = e; mode = m; clear = c;
        x.tag = tag; x.z = ez; x.done = ed; x.ready = er; x.busy = eb;
        x.chk_al = 1'b0; x.z_al = '0;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        check({x.tag, ".z"},     32'(z),        32'(x.z));
        check({x.tag, ".done"},  32'(done),     32'(x.done));
        check({x.tag, ".ready"}, 32'(in_ready), 32'(x.ready));
        check({x.tag, ".busy"},  32'(busy),     32'(x.busy));
        $display("step %-10s z=%b done=%b ready=%b busy=%b z_al=%b", x.tag, z, done, in_ready, busy, z_al);
    endtask

    // Same as step, additionally checking the active-low N=3 instance.
    task automatic step_al(input string tag, input logic r, input logic v, input logic [2:0] s,
                           input logic [1:0] m, input logic [7:0] ezal);
        exp_t x;
        rst = r; in_valid = v; sel_al = s; en = 1'b1; mode = m; clear = 1'b0;
        x.tag = tag; x.z = '0; x.done = 1'b0; x.ready = 1'b1; x.busy = 1'b0;
        x.chk_al = 1'b1; x.z_al = ezal;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        if (x.chk_al) check({x.tag, ".z_al"}, 32'(z_al), 32'(x.z_al));
        $display("step %-10s z_al=%b", x.tag, z_al);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; sel = '0; en = 1'b0; mode = MODE_LEVEL; clear = 1'b0; sel_al = '0;

        // Reset values
        step("reset", 1, 0, 0, 0, MODE_LEVEL, 0, 4'b0000, 0, 1, 0);
        step_al("reset_al", 1, 0, 3'd0, MODE_LEVEL, 8'hFF);

        // 1. LEVEL sweep, back-to-back accepts from HOLD
        step("lvl0", 0, 1, 2'd0, 1, MODE_LEVEL, 0, 4'b1000, 1, 1, 0);
        step("lvl1", 0, 1, 2'd1, 1, MODE_LEVEL, 0, 4'b0100, 1, 1, 0);
        step("lvl2", 0, 1, 2'd2, 1, MODE_LEVEL, 0, 4'b0010, 1, 1, 0);
        step("lvl3", 0, 1, 2'd3, 1, MODE_LEVEL, 0, 4'b0001, 1, 1, 0);

        // 2. Enable off, then LEVEL again, then hold
        step("en_off", 0, 1, 2'd1, 0, MODE_LEVEL, 0, 4'b0000, 0, 1, 0);
        step("lvl_sel2", 0, 1, 2'd2, 1, MODE_LEVEL, 0, 4'b0010, 1, 1, 0);
        step("hold", 0, 0, 2'd0, 0, MODE_LEVEL, 0, 4'b0010, 0, 1, 0);

        // Reserved mode behaves as LEVEL
        step("rsv_mode", 0, 1, 2'd1, 1, 2'b11, 0, 4'b0100, 1, 1, 0);

        // 3. PULSE sel=3, 3 cycles; in_valid while busy ignored
        step("pulse_c1", 0, 1, 2'd3, 1, MODE_PULSE, 0, 4'b0001, 0, 0, 1);
        step("pulse_c2", 0, 1, 2'd0, 1, MODE_LEVEL, 0, 4'b0001, 0, 0, 1);
        step("pulse_c3", 0, 1, 2'd1, 1, MODE_SCAN,  0, 4'b0001, 0, 0, 1);
        step("pulse_end", 0, 0, 2'd0, 0, MODE_LEVEL, 0, 4'b0000, 1, 1, 0);
        step("pulse_idle", 0, 0, 2'd0, 0, MODE_LEVEL, 0, 4'b0000, 0, 1, 0);

        // 4. SCAN sel=1 then sel=3 (single cycle)
        step("scan1_a", 0, 1, 2'd1, 1, MODE_SCAN, 0, 4'b0100, 0, 0, 1);
        step("scan1_b", 0, 0, 2'd0, 0, MODE_LEVEL, 0, 4'b0010, 0, 0, 1);
        step("scan1_c", 0, 0, 2'd0, 0, MODE_LEVEL, 0, 4'b0001, 0, 0, 1);
        step("scan1_end", 0, 0, 2'd0, 0, MODE_LEVEL, 0, 4'b0000, 1, 1, 0);
        step("scan3_a", 0, 1, 2'd3, 1, MODE_SCAN, 0, 4'b0001, 0, 0, 1);
        step("scan3_end", 0, 0, 2'd0, 0, MODE_LEVEL, 0, 4'b0000, 1, 1, 0);

        // 5. Clear during SCAN at z=0010
        step("scan0_a", 0, 1, 2'd0, 1, MODE_SCAN, 0, 4'b1000, 0, 0, 1);
        step("scan0_b", 0, 0, 2'd0, 0, MODE_LEVEL, 0, 4'b0100, 0, 0, 1);
        step("scan0_c", 0, 0, 2'd0, 0, MODE_LEVEL, 0, 4'b0010, 0, 0, 1);
        step("clr_scan", 0, 0, 2'd0, 0, MODE_LEVEL, 1, 4'b0000, 0, 1, 0);
        // Clear beats a same-cycle accept
        step("clr_acc", 0, 1, 2'd2, 1, MODE_LEVEL, 1, 4'b0000, 0, 1, 0);
        // rst mid-PULSE
        step("pulse_b", 0, 1, 2'd1, 1, MODE_PULSE, 0, 4'b0100, 0, 0, 1);
        step("rst_pulse", 1, 0, 2'd0, 0, MODE_LEVEL, 0, 4'b0000, 0, 1, 0);

        // 6. Active-low N=3 instance: LEVEL sel=5 clears only z[5]
        step_al("al_sel5", 0, 1, 3'd5, MODE_LEVEL, 8'b1111_1011);
        step_al("al_hold", 0, 0, 3'd0, MODE_LEVEL, 8'b1111_1011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
